// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall control bundle between the MIPS pipeline datapath and hazard_stall_unit.
// master = pipeline side (drives stage info), slave = the stall/flush controller.
interface hazard_stall_unit_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
);
  logic [RA_W-1:0]  id_rs;
  logic [RA_W-1:0]  id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_is_branch;
  logic             id_taken;
  logic             id_ex_memread;
  logic             id_ex_regwrite;
  logic [RA_W-1:0]  id_ex_regwraddr;
  logic             ex_mem_memread;
  logic [RA_W-1:0]  ex_mem_regwraddr;
  logic             mem_busy;

  logic             pc_hold;
  logic             if_id_hold;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             pipe_freeze;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic [CNT_W-1:0] freeze_cycles;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch, id_taken,
           id_ex_memread, id_ex_regwrite, id_ex_regwraddr,
           ex_mem_memread, ex_mem_regwraddr, mem_busy,
    input  pc_hold, if_id_hold, if_id_flush, id_ex_bubble, pipe_freeze,
           stall_cycles, flush_count, freeze_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch, id_taken,
           id_ex_memread, id_ex_regwrite, id_ex_regwraddr,
           ex_mem_memread, ex_mem_regwraddr, mem_busy,
    output pc_hold, if_id_hold, if_id_flush, id_ex_bubble, pipe_freeze,
           stall_cycles, flush_count, freeze_cycles
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush/freeze controller for the 5-stage MIPS pipeline (load-use, branch-in-ID, mem busy).
// Define HAZARD_STATS_EN to build the bubble/flush/freeze statistics counters.
module hazard_stall_unit #(
  parameter int RA_W      = 5,
  parameter int LB_STALLS = 2,
  parameter int CNT_W     = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  hazard_stall_unit_if.slave  hz
);

  typedef enum logic [1:0] {RUN, STALL, FREEZE} state_t;

  localparam logic [1:0] LB_NEED = 2'(LB_STALLS);

  state_t     state, state_nx;
  state_t     saved, saved_nx;
  state_t     eff;
  logic [1:0] cnt, cnt_nx;
  logic [1:0] need;
  logic       match_ex, match_mem;

  always_comb begin
    match_ex  = (hz.id_ex_regwraddr != '0) &&
                ((hz.id_use_rs && (hz.id_ex_regwraddr == hz.id_rs)) ||
                 (hz.id_use_rt && (hz.id_ex_regwraddr == hz.id_rt)));
    match_mem = (hz.ex_mem_regwraddr != '0) &&
                ((hz.id_use_rs && (hz.ex_mem_regwraddr == hz.id_rs)) ||
                 (hz.id_use_rt && (hz.ex_mem_regwraddr == hz.id_rt)));
  end

  // Hazards the EX bypass cannot cover: a load result is not ready, or the branch reads operands in ID.
  always_comb begin
    need = 2'd0;
    if (hz.id_ex_memread && match_ex && hz.id_is_branch)        need = LB_NEED;
    else if (hz.id_ex_memread && match_ex)                      need = 2'd1;
    else if (hz.id_is_branch && hz.id_ex_regwrite && match_ex)  need = 2'd1;
    else if (hz.id_is_branch && hz.ex_mem_memread && match_mem) need = 2'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= RUN;
      saved <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_nx;
      saved <= saved_nx;
      cnt   <= cnt_nx;
    end
  end

  // NOTE: every output and next-state value gets a default first so no path infers a latch.
  always_comb begin
    state_nx        = state;
    saved_nx        = saved;
    cnt_nx          = cnt;
    hz.pc_hold      = 1'b0;
    hz.if_id_hold   = 1'b0;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_bubble = 1'b0;
    hz.pipe_freeze  = 1'b0;
    // A released freeze behaves exactly like the state it interrupted, in the same cycle.
    eff             = (state == FREEZE) ? saved : state;

    if (!reset_n) begin
      state_nx = RUN;
    end else if (hz.mem_busy) begin
      state_nx       = FREEZE;
      saved_nx       = eff;
      hz.pc_hold     = 1'b1;
      hz.if_id_hold  = 1'b1;
      hz.pipe_freeze = 1'b1;
    end else begin
      unique case (eff)
        RUN: begin
          state_nx = RUN;
          if (need != 2'd0) begin
            hz.pc_hold      = 1'b1;
            hz.if_id_hold   = 1'b1;
            hz.id_ex_bubble = 1'b1;
            cnt_nx          = need - 2'd1;
            if (need > 2'd1) state_nx = STALL;
          end else if (hz.id_taken) begin
            hz.if_id_flush = 1'b1;
          end
        end
        STALL: begin
          hz.pc_hold      = 1'b1;
          hz.if_id_hold   = 1'b1;
          hz.id_ex_bubble = 1'b1;
          cnt_nx          = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
          state_nx        = (cnt <= 2'd1) ? RUN : STALL;
        end
        default: begin
          state_nx = RUN;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_q, flush_q, freeze_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_q  <= '0;
      flush_q  <= '0;
      freeze_q <= '0;
    end else begin
      if (hz.id_ex_bubble) stall_q  <= stall_q  + CNT_W'(1);
      if (hz.if_id_flush)  flush_q  <= flush_q  + CNT_W'(1);
      if (hz.pipe_freeze)  freeze_q <= freeze_q + CNT_W'(1);
    end
  end

  assign hz.stall_cycles  = reset_n ? stall_q  : '0;
  assign hz.flush_count   = reset_n ? flush_q  : '0;
  assign hz.freeze_cycles = reset_n ? freeze_q : '0;
`else
  assign hz.stall_cycles  = '0;
  assign hz.flush_count   = '0;
  assign hz.freeze_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: expected control vectors are queued as each step is
// driven and popped when the outputs are sampled; statistics are checked against a running tally.
module tb_hazard_stall_unit;
  localparam int RA_W  = 5;
  localparam int CNT_W = 32;

  // Control vector layout: {pc_hold, if_id_hold, if_id_flush, id_ex_bubble, pipe_freeze}
  localparam logic [4:0] NONE  = 5'b00000;
  localparam logic [4:0] BUB   = 5'b11010;
  localparam logic [4:0] FLUSH = 5'b00100;
  localparam logic [4:0] FRZ   = 5'b11001;

  typedef struct {
    string      tag;
    logic [4:0] ctl;
  } exp_t;

  logic clk;
  logic reset_n;
  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   m_stall, m_flush, m_freeze;

  hazard_stall_unit_if #(.RA_W(RA_W), .CNT_W(CNT_W)) hz ();

  hazard_stall_unit #(.RA_W(RA_W), .LB_STALLS(2), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    hz.id_rs = '0; hz.id_rt = '0; hz.id_use_rs = 1'b0; hz.id_use_rt = 1'b0;
    hz.id_is_branch = 1'b0; hz.id_taken = 1'b0;
    hz.id_ex_memread = 1'b0; hz.id_ex_regwrite = 1'b0; hz.id_ex_regwraddr = '0;
    hz.ex_mem_memread = 1'b0; hz.ex_mem_regwraddr = '0;
    hz.mem_busy = 1'b0;
  endtask

  task automatic id_stage(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic br, input logic tk);
    hz.id_rs = rs; hz.id_rt = rt; hz.id_use_rs = urs; hz.id_use_rt = urt;
    hz.id_is_branch = br; hz.id_taken = tk;
  endtask

  task automatic ex_stage(input logic mr, input logic rw, input logic [4:0] wa);
    hz.id_ex_memread = mr; hz.id_ex_regwrite = rw; hz.id_ex_regwraddr = wa;
  endtask

  task automatic mem_stage(input logic mr, input logic [4:0] wa);
    hz.ex_mem_memread = mr; hz.ex_mem_regwraddr = wa;
  endtask

  // Inputs are already driven (after a falling edge); sample 1 ns later, then advance a cycle.
  task automatic step(input string tag, input logic [4:0] exp);
    exp_t e;
    sb.push_back('{tag, exp});
    #1;
    e = sb.pop_front();
    check(e.tag, 32'({hz.pc_hold, hz.if_id_hold, hz.if_id_flush, hz.id_ex_bubble, hz.pipe_freeze}),
          32'(e.ctl));
`ifdef HAZARD_STATS_EN
    check({e.tag, ".stall_cycles"},  hz.stall_cycles,  m_stall);
    check({e.tag, ".flush_count"},   hz.flush_count,   m_flush);
    check({e.tag, ".freeze_cycles"}, hz.freeze_cycles, m_freeze);
`else
    check({e.tag, ".stall_cycles"},  hz.stall_cycles,  0);
    check({e.tag, ".flush_count"},   hz.flush_count,   0);
    check({e.tag, ".freeze_cycles"}, hz.freeze_cycles, 0);
`endif
    if (!reset_n) begin
      m_stall = 0; m_flush = 0; m_freeze = 0;
    end else begin
      m_stall  += int'(e.ctl[1]);
      m_flush  += int'(e.ctl[2]);
      m_freeze += int'(e.ctl[0]);
    end
    @(negedge clk);
  endtask

  initial begin
    m_stall = 0; m_flush = 0; m_freeze = 0;
    reset_n = 1'b0;
    idle();
    @(negedge clk);

    // Outputs stay low under reset even with a live load-use hazard and a busy memory.
    ex_stage(1, 1, 5'd8); id_stage(5'd8, 5'd0, 1, 0, 0, 0);
    step("reset_loaduse", NONE);
    hz.mem_busy = 1'b1;
    step("reset_busy", NONE);
    idle();
    step("reset_idle", NONE);
    reset_n = 1'b1;
    step("idle", NONE);

    // lw $t0 in EX; add $t1,$t0,$t2 in ID -> one bubble, then the load moves to MEM.
    ex_stage(1, 1, 5'd8); id_stage(5'd8, 5'd10, 1, 1, 0, 0);
    step("loaduse", BUB);
    ex_stage(0, 0, 5'd0); mem_stage(1, 5'd8);
    step("loaduse_after", NONE);

    // lw $t0 in EX; beq $t0,$t1 in ID -> two bubbles; the second ignores the MEM-load match.
    idle();
    ex_stage(1, 1, 5'd8); id_stage(5'd8, 5'd9, 1, 1, 1, 0);
    step("ldbr_1", BUB);
    ex_stage(0, 0, 5'd0); mem_stage(1, 5'd8);
    step("ldbr_2", BUB);
    mem_stage(0, 5'd0);
    step("ldbr_done", NONE);

    // Register $0 never creates a dependency.
    idle();
    ex_stage(1, 1, 5'd0); id_stage(5'd0, 5'd0, 1, 1, 0, 0);
    step("load_r0", NONE);

    // ALU result in EX feeding an ALU op in ID is forwarded.
    idle();
    ex_stage(0, 1, 5'd8); id_stage(5'd9, 5'd8, 1, 1, 0, 0);
    step("alu_fwd", NONE);

    // Unused operand field matching the load destination is not a hazard.
    idle();
    ex_stage(1, 1, 5'd8); id_stage(5'd9, 5'd8, 1, 0, 0, 0);
    step("unused_rt", NONE);

    // Branch in ID reading an ALU result still in EX -> one bubble.
    idle();
    ex_stage(0, 1, 5'd12); id_stage(5'd12, 5'd3, 1, 1, 1, 0);
    step("alu_branch", BUB);
    idle();
    step("alu_branch_after", NONE);

    // Branch in ID reading a load that is in MEM -> one bubble.
    mem_stage(1, 5'd7); id_stage(5'd2, 5'd7, 1, 1, 1, 0);
    step("memload_branch", BUB);
    idle();
    step("memload_branch_after", NONE);

    // Taken branch, no hazard -> single-cycle flush.
    id_stage(5'd1, 5'd2, 1, 1, 1, 1);
    step("taken", FLUSH);
    idle();
    step("taken_after", NONE);

    // Taken beq while stalled: flush only once the stall ends.
    ex_stage(1, 1, 5'd8); id_stage(5'd8, 5'd9, 1, 1, 1, 1);
    step("taken_stall_1", BUB);
    ex_stage(0, 0, 5'd0);
    step("taken_stall_2", BUB);
    step("taken_stall_flush", FLUSH);
    idle();
    step("taken_stall_after", NONE);

    // Memory busy outranks flushes and hazards.
    id_stage(5'd1, 5'd2, 1, 1, 1, 1); hz.mem_busy = 1'b1;
    step("busy_taken", FRZ);
    idle(); ex_stage(1, 1, 5'd8); id_stage(5'd8, 5'd0, 1, 0, 0, 0); hz.mem_busy = 1'b1;
    step("busy_loaduse", FRZ);
    hz.mem_busy = 1'b0;
    step("busy_release_loaduse", BUB);
    idle();
    step("busy_release_after", NONE);

    // Freeze during stall cycle 1 of 2: three freeze cycles, then the remaining bubble.
    ex_stage(1, 1, 5'd8); id_stage(5'd8, 5'd9, 1, 1, 1, 0);
    step("frz_stall_1", BUB);
    idle(); id_stage(5'd8, 5'd9, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      hz.mem_busy = 1'b1;
      step($sformatf("frz_cycle_%0d", i), FRZ);
    end
    hz.mem_busy = 1'b0;
    step("frz_stall_2", BUB);
    idle();
    step("frz_after", NONE);

    // Reset in the middle of a stall: outputs drop at once, release comes back in RUN.
    ex_stage(1, 1, 5'd8); id_stage(5'd8, 5'd9, 1, 1, 1, 0);
    step("rst_stall_1", BUB);
    reset_n = 1'b0;
    step("rst_stall_reset", NONE);
    reset_n = 1'b1;
    idle(); id_stage(5'd1, 5'd2, 1, 1, 1, 1);
    step("rst_stall_released", FLUSH);
    idle();
    step("rst_stall_idle", NONE);

    // Reset in the middle of a freeze.
    hz.mem_busy = 1'b1;
    step("rst_frz_1", FRZ);
    reset_n = 1'b0;
    step("rst_frz_reset", NONE);
    reset_n = 1'b1; hz.mem_busy = 1'b0;
    ex_stage(1, 1, 5'd8); id_stage(5'd0, 5'd8, 0, 1, 0, 0);
    step("rst_frz_released", BUB);
    idle();
    step("rst_frz_idle", NONE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
